// File: rtl/wb_trace_writer.sv
// wb_trace_writer
// Commit-trace writer at the writeback end of the pipelined CPU. Each retiring
// register write and the retiring HLT become one record in a small FIFO. The
// records are streamed out over a valid/ready port, so a monitor sees an
// in-order retirement log and never has to probe pipeline internals.
//
// Optional feature: define TRACE_TIMESTAMP_EN to add a 16-bit free-running
// cycle counter. Its capture-cycle value is prepended to every record.
//
// Ports:
//   clk, rst_n    CPU clock; synchronous active-low reset.
//   cap_en        capture enable; 0 ignores all writeback events.
//   wb_regwrite, wb_hlt, wb_reg_rd, wb_data, wb_pc_next
//                 MEM/WB retirement signals.
//   trace_valid / trace_ready / trace_data
//                 record stream. Record layout is
//                 {[ts[15:0]], hlt, rd[3:0], data[15:0], pc_next[15:0]}.
//   trace_done    halt record consumed and FIFO empty.
//   overflow      sticky; at least one record was dropped.
//   drop_cnt      saturating count of dropped records.
//   fsm_state     debug view of the FSM
//                 (0 RUN, 1 HALT_PEND, 2 DRAIN, 3 DONE).
//   fifo_count    debug view of the FIFO occupancy.
//
// Handshake: a record transfers on a cycle where trace_valid and trace_ready
// are both 1. The producer holds trace_data stable while trace_valid=1 and
// trace_ready=0. trace_ready may be high while trace_valid=0; this has no
// effect.
module wb_trace_writer #(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cap_en,
    input  logic                         wb_regwrite,
    input  logic                         wb_hlt,
    input  logic [3:0]                   wb_reg_rd,
    input  logic [15:0]                  wb_data,
    input  logic [15:0]                  wb_pc_next,
    output logic                         trace_valid,
    input  logic                         trace_ready,
`ifdef TRACE_TIMESTAMP_EN
    output logic [52:0]                  trace_data,
`else
    output logic [36:0]                  trace_data,
`endif
    output logic                         trace_done,
    output logic                         overflow,
    output logic [DROP_W-1:0]            drop_cnt,
    output logic [1:0]                   fsm_state,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
`ifdef TRACE_TIMESTAMP_EN
    localparam int RW = 53;
`else
    localparam int RW = 37;
`endif

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HALT_PEND = 2'd1,
        DRAIN     = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t          state;
    logic [RW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [RW-1:0]   hold;
    logic [RW-1:0]   rec;
    logic [RW-1:0]   push_rec;
    logic            evt;
    logic            pop;
    logic            push_ok;
    logic            push;

`ifdef TRACE_TIMESTAMP_EN
    logic [15:0]     ts;

    // Reset holds the counter at 0, so the first cycle after release reads 0.
    always_ff @(posedge clk) begin
        if (!rst_n) ts <= 16'd0;
        else        ts <= ts + 16'd1;
    end
`endif

    // A pure HLT retirement carries no register write, so rd and data are zeroed.
    always_comb begin
        rec = {
`ifdef TRACE_TIMESTAMP_EN
               ts,
`endif
               wb_hlt,
               wb_regwrite ? wb_reg_rd : 4'd0,
               wb_regwrite ? wb_data   : 16'd0,
               wb_pc_next};
    end

    assign evt         = cap_en & (wb_regwrite | wb_hlt);
    assign trace_valid = (count != '0);
    assign pop         = trace_valid & trace_ready;
    // A full FIFO still accepts a push when its head leaves in the same cycle.
    assign push_ok     = (count != FULL) | pop;
    assign trace_data  = trace_valid ? mem[rd_ptr] : '0;
    assign fsm_state   = state;
    assign fifo_count  = count;

    // Only RUN captures live events. HALT_PEND replays the held halt record.
    always_comb begin
        push     = 1'b0;
        push_rec = rec;
        case (state)
            RUN:       push = evt & push_ok;
            HALT_PEND: begin
                push     = push_ok;
                push_rec = hold;
            end
            default:   push = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_rec;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RUN;
            hold       <= '0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
            trace_done <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (evt) begin
                        if (wb_hlt) begin
                            // The halt record is never dropped; park it if no room.
                            if (push_ok) begin
                                state <= DRAIN;
                            end else begin
                                hold  <= rec;
                                state <= HALT_PEND;
                            end
                        end else if (!push_ok) begin
                            overflow <= 1'b1;
                            if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
                        end
                    end
                end
                HALT_PEND: begin
                    if (push_ok) state <= DRAIN;
                end
                DRAIN: begin
                    // No pushes happen here, so an empty FIFO means the halt record is gone.
                    if (count == '0) begin
                        state      <= DONE;
                        trace_done <= 1'b1;
                    end
                end
                default: begin
                    trace_done <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_trace_writer.sv
module tb_wb_trace_writer;
  localparam int DEPTH = 8;
`ifdef TRACE_TIMESTAMP_EN
  localparam int TW = 53;
`else
  localparam int TW = 37;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cap_en = 1'b0;
  logic          wb_regwrite = 1'b0;
  logic          wb_hlt = 1'b0;
  logic [3:0]    wb_reg_rd = '0;
  logic [15:0]   wb_data = '0;
  logic [15:0]   wb_pc_next = '0;
  logic          trace_valid;
  logic          trace_ready = 1'b0;
  logic [TW-1:0] trace_data;
  logic          trace_done;
  logic          overflow;
  logic [7:0]    drop_cnt;
  logic [1:0]    fsm_state;
  logic [3:0]    fifo_count;

  wb_trace_writer #(.DEPTH(DEPTH), .DROP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cap_en(cap_en), .wb_regwrite(wb_regwrite),
    .wb_hlt(wb_hlt), .wb_reg_rd(wb_reg_rd), .wb_data(wb_data),
    .wb_pc_next(wb_pc_next), .trace_valid(trace_valid),
    .trace_ready(trace_ready), .trace_data(trace_data),
    .trace_done(trace_done), .overflow(overflow), .drop_cnt(drop_cnt),
    .fsm_state(fsm_state), .fifo_count(fifo_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  string tname = "none";

  // behavioural reference: record queue plus halt bookkeeping
  logic [TW-1:0] exp_q[$];
  logic [TW-1:0] pop_log[$];
  logic [TW-1:0] m_held;
  int            m_phase;   // 0 run, 1 halt pending, 2 draining, 3 done
  int            m_drops;
  bit            m_ovf;
  bit            m_done;
  int            m_ts;
  int            cyc;
  int            last_pop_cyc;

  function automatic logic [TW-1:0] make_rec(logic h, logic rw, logic [3:0] rd,
                                             logic [15:0] d, logic [15:0] pc, int ts);
    logic [36:0] base;
    logic [15:0] t;
    t    = ts[15:0];
    base = {h, rw ? rd : 4'd0, rw ? d : 16'd0, pc};
`ifdef TRACE_TIMESTAMP_EN
    return {t, base};
`else
    return base;
`endif
  endfunction

  task automatic model_edge();
    int            sz;
    bit            pop;
    bit            room;
    bit            ev;
    logic [TW-1:0] rec;
    if (!rst_n) begin
      exp_q.delete();
      m_phase = 0; m_drops = 0; m_ovf = 0; m_done = 0; m_ts = 0; m_held = '0;
    end else begin
      sz   = exp_q.size();
      pop  = (sz > 0) && trace_ready;
      room = (sz < DEPTH) || pop;
      ev   = cap_en && (wb_regwrite || wb_hlt);
      rec  = make_rec(wb_hlt, wb_regwrite, wb_reg_rd, wb_data, wb_pc_next, m_ts);
      if (pop) void'(exp_q.pop_front());
      case (m_phase)
        0: if (ev) begin
             if (room) begin
               exp_q.push_back(rec);
               if (wb_hlt) m_phase = 2;
             end else if (wb_hlt) begin
               m_held  = rec;
               m_phase = 1;
             end else begin
               m_ovf = 1;
               if (m_drops < 255) m_drops++;
             end
           end
        1: if (room) begin
             exp_q.push_back(m_held);
             m_phase = 2;
           end
        2: if (sz == 0) begin
             m_phase = 3;
             m_done  = 1;
           end
        default: m_done = 1;
      endcase
      m_ts = (m_ts + 1) & 16'hFFFF;
    end
  endtask

  // one clock: observe pre-edge handshake, advance model, score DUT after edge
  task automatic tick();
    bit            dut_pop;
    logic [TW-1:0] head;
    logic [TW-1:0] e_data;
    bit            e_valid;
    dut_pop = trace_valid && trace_ready;
    head    = trace_data;
    @(posedge clk);
    model_edge();
    cyc++;
    if (dut_pop && rst_n) begin
      pop_log.push_back(head);
      last_pop_cyc = cyc;
    end
    #1;
    e_valid = exp_q.size() > 0;
    e_data  = e_valid ? exp_q[0] : '0;
    checks++;
    if (trace_valid !== e_valid) begin
      errors++; $display("FAIL %s valid: got %b exp %b cyc %0d", tname, trace_valid, e_valid, cyc);
    end
    checks++;
    if (trace_data !== e_data) begin
      errors++; $display("FAIL %s data: got %h exp %h cyc %0d", tname, trace_data, e_data, cyc);
    end
    checks++;
    if (overflow !== m_ovf) begin
      errors++; $display("FAIL %s overflow: got %b exp %b cyc %0d", tname, overflow, m_ovf, cyc);
    end
    checks++;
    if (drop_cnt !== m_drops[7:0]) begin
      errors++; $display("FAIL %s drop_cnt: got %0d exp %0d cyc %0d", tname, drop_cnt, m_drops, cyc);
    end
    checks++;
    if (trace_done !== m_done) begin
      errors++; $display("FAIL %s done: got %b exp %b cyc %0d", tname, trace_done, m_done, cyc);
    end
    checks++;
    if (fifo_count !== 4'(exp_q.size())) begin
      errors++; $display("FAIL %s count: got %0d exp %0d cyc %0d", tname, fifo_count, exp_q.size(), cyc);
    end
    checks++;
    if (fsm_state !== 2'(m_phase)) begin
      errors++; $display("FAIL %s state: got %0d exp %0d cyc %0d", tname, fsm_state, m_phase, cyc);
    end
  endtask

  // driver tasks
  task automatic drive_ev(logic rw, logic h, logic [3:0] rd, logic [15:0] d, logic [15:0] pc);
    cap_en = 1'b1; wb_regwrite = rw; wb_hlt = h;
    wb_reg_rd = rd; wb_data = d; wb_pc_next = pc;
  endtask

  task automatic drive_idle();
    cap_en = 1'b0; wb_regwrite = 1'b0; wb_hlt = 1'b0;
    wb_reg_rd = '0; wb_data = '0; wb_pc_next = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic fill(int n);
    for (int i = 0; i < n; i++) begin
      drive_ev(1'b1, 1'b0, 4'($urandom_range(0, 15)), 16'($urandom), 16'(i * 2));
      tick();
    end
    drive_idle();
  endtask

  task automatic test_reset();
    tname = "reset";
    trace_ready = 1'b1;
    drive_ev(1'b1, 1'b0, 4'd1, 16'hAAAA, 16'h0002);
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({trace_valid, trace_data, trace_done, overflow, drop_cnt, fifo_count, fsm_state} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got v%b d%h done%b ovf%b drop%0d cnt%0d st%0d exp all zero",
               trace_valid, trace_data, trace_done, overflow, drop_cnt, fifo_count, fsm_state);
    end
    rst_n = 1'b1;
    drive_idle();
    tick();
  endtask

  task automatic test_single_write();
    logic [36:0] exp_low;
    tname = "single_write";
    exp_low = {1'b0, 4'h3, 16'h1234, 16'h0008};
    trace_ready = 1'b1;
    drive_ev(1'b1, 1'b0, 4'd3, 16'h1234, 16'h0008);
    tick();
    drive_idle();
    checks++;
    if (trace_valid !== 1'b1 || trace_data[36:0] !== exp_low) begin
      errors++; $display("FAIL single_write head: got v%b %h exp v1 %h", trace_valid, trace_data[36:0], exp_low);
    end
    tick();
    checks++;
    if (trace_valid !== 1'b0) begin
      errors++; $display("FAIL single_write empty: got v%b exp v0", trace_valid);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] wd[10];
    int          n;
    tname = "overflow";
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wd[i] = 16'($urandom);
      drive_ev(1'b1, 1'b0, 4'(i), wd[i], 16'(i * 2));
      tick();
    end
    drive_idle();
    checks++;
    if (fifo_count !== 4'd8 || overflow !== 1'b1 || drop_cnt !== 8'd2) begin
      errors++; $display("FAIL overflow status: got cnt%0d ovf%b drop%0d exp cnt8 ovf1 drop2", fifo_count, overflow, drop_cnt);
    end
    pop_log.delete();
    trace_ready = 1'b1;
    n = 0;
    while (trace_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (pop_log.size() != 8) begin
      errors++; $display("FAIL overflow drained: got %0d exp 8", pop_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (pop_log[i][31:16] !== wd[i]) begin
          errors++; $display("FAIL overflow order[%0d]: got %h exp %h", i, pop_log[i][31:16], wd[i]);
        end
      end
    end
  endtask

  task automatic test_full_pop();
    tname = "full_pop";
    trace_ready = 1'b0;
    fill(8);
    trace_ready = 1'b1;
    drive_ev(1'b1, 1'b0, 4'd9, 16'hBEEF, 16'h0100);
    tick();
    drive_idle();
    trace_ready = 1'b0;
    checks++;
    if (drop_cnt !== 8'd2 || fifo_count !== 4'd8) begin
      errors++; $display("FAIL full_pop status: got drop%0d cnt%0d exp drop2 cnt8", drop_cnt, fifo_count);
    end
  endtask

  task automatic test_halt_full();
    int n;
    tname = "halt_full";
    do_reset();
    trace_ready = 1'b0;
    fill(8);
    drive_ev(1'b0, 1'b1, 4'd7, 16'h5555, 16'h0040);
    tick();
    checks++;
    if (fsm_state !== 2'd1 || drop_cnt !== 8'd0 || fifo_count !== 4'd8) begin
      errors++; $display("FAIL halt_full pend: got st%0d drop%0d cnt%0d exp st1 drop0 cnt8", fsm_state, drop_cnt, fifo_count);
    end
    for (int i = 0; i < 3; i++) begin
      drive_ev(1'b1, 1'b0, 4'd2, 16'($urandom), 16'h0042);
      tick();
    end
    checks++;
    if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL halt_full nodrop: got drop%0d ovf%b exp 0 0", drop_cnt, overflow);
    end
    pop_log.delete();
    trace_ready = 1'b1;
    n = 0;
    while (!trace_done && n < 40) begin
      drive_ev(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'd5, 16'($urandom), 16'h0080);
      tick();
      n++;
    end
    drive_idle();
    checks++;
    if (!trace_done) begin
      errors++; $display("FAIL halt_full timeout: got done0 exp done1");
    end
    checks++;
    if (pop_log.size() != 9) begin
      errors++; $display("FAIL halt_full records: got %0d exp 9", pop_log.size());
    end else begin
      checks++;
      if (pop_log[8][36:16] !== {1'b1, 4'd0, 16'd0}) begin
        errors++; $display("FAIL halt_full last: got %h exp hlt=1 rd=0 data=0", pop_log[8][36:16]);
      end
    end
    checks++;
    if (cyc - last_pop_cyc != 1) begin
      errors++; $display("FAIL halt_full done_timing: got %0d exp 1", cyc - last_pop_cyc);
    end
    for (int i = 0; i < 3; i++) begin
      drive_ev(1'b1, 1'b1, 4'd1, 16'h1, 16'h1);
      tick();
    end
    drive_idle();
  endtask

  task automatic test_drop_sat();
    tname = "drop_sat";
    do_reset();
    trace_ready = 1'b0;
    fill(8);
    for (int i = 0; i < 300; i++) begin
      drive_ev(1'b1, 1'b0, 4'd4, 16'($urandom), 16'h0200);
      tick();
    end
    drive_idle();
    checks++;
    if (drop_cnt !== 8'hFF || overflow !== 1'b1) begin
      errors++; $display("FAIL drop_sat sat: got drop%h ovf%b exp ff 1", drop_cnt, overflow);
    end
    do_reset();
    checks++;
    if ({trace_valid, trace_data, trace_done, overflow, drop_cnt, fifo_count, fsm_state} !== '0) begin
      errors++; $display("FAIL drop_sat reset: got v%b ovf%b drop%0d cnt%0d st%0d exp all zero",
                         trace_valid, overflow, drop_cnt, fifo_count, fsm_state);
    end
  endtask

  task automatic test_random();
    tname = "random";
    do_reset();
    for (int i = 0; i < 600; i++) begin
      trace_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 9) != 0)
        drive_ev(1'($urandom_range(0, 1)), ($urandom_range(0, 60) == 0),
                 4'($urandom), 16'($urandom), 16'($urandom));
      else
        drive_idle();
      cap_en = ($urandom_range(0, 7) != 0) ? cap_en : 1'b0;
      rst_n  = (i == 300) ? 1'b0 : 1'b1;
      tick();
    end
    rst_n = 1'b1;
    drive_idle();
  endtask

`ifdef TRACE_TIMESTAMP_EN
  task automatic test_timestamp();
    tname = "timestamp";
    trace_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    drive_ev(1'b1, 1'b0, 4'd1, 16'h0011, 16'h0022);
    tick();
    drive_idle();
    checks++;
    if (trace_data[52:37] !== 16'd4) begin
      errors++; $display("FAIL timestamp ts5: got %0d exp 4", trace_data[52:37]);
    end
    trace_ready = 1'b1;
    tick();
    trace_ready = 1'b0;
    while (m_ts != 16'hFFFF) tick();
    drive_ev(1'b1, 1'b0, 4'd2, 16'h0033, 16'h0044);
    tick();
    drive_ev(1'b1, 1'b0, 4'd3, 16'h0055, 16'h0066);
    tick();
    drive_idle();
    checks++;
    if (trace_data[52:37] !== 16'hFFFF) begin
      errors++; $display("FAIL timestamp wrap_a: got %h exp ffff", trace_data[52:37]);
    end
    trace_ready = 1'b1;
    tick();
    checks++;
    if (trace_data[52:37] !== 16'h0000) begin
      errors++; $display("FAIL timestamp wrap_b: got %h exp 0000", trace_data[52:37]);
    end
    tick();
  endtask
`endif

  initial begin
    cyc = 0;
    last_pop_cyc = 0;
    test_reset();
    test_single_write();
    test_overflow();
    test_full_pop();
    test_halt_full();
    test_drop_sat();
    test_random();
`ifdef TRACE_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
